// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: lets NREQ requesters share one sequential multiplier
// engine. Requesters take turns in round-robin order, and only one multiply
// runs at a time. The winner's operands are sent to the engine, the design
// waits for done (or gives up after TIMEOUT cycles), and the product is then
// returned tagged with the winner's ID.
module mult_share_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic                  mul_done,
  input  logic [2*WIDTH-1:0]    mul_product,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_product,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int CNTW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]         r_state;
  logic [IDW-1:0]     r_lastGrant;
  logic [IDW-1:0]     r_id;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [CNTW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic               r_err;

  logic               w_found;
  logic [IDW-1:0]     w_grantId;
  logic [IDW:0]       w_cand;
  logic [NREQ-1:0]    w_grant;
  logic [WIDTH-1:0]   w_selA;
  logic [WIDTH-1:0]   w_selB;

  // Round-robin search. Start one past the last winner and wrap modulo NREQ,
  // so requester counts that are not a power of two also work.
  always_comb begin
    w_found   = 1'b0;
    w_grantId = '0;
    w_cand    = '0;
    w_grant   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = {1'b0, r_lastGrant} + (IDW+1)'(k);
      if (w_cand >= (IDW+1)'(NREQ)) begin
        w_cand = w_cand - (IDW+1)'(NREQ);
      end
      if (!w_found && req_valid[w_cand[IDW-1:0]]) begin
        w_found   = 1'b1;
        w_grantId = w_cand[IDW-1:0];
      end
    end
    if (w_found) begin
      w_grant[w_grantId] = 1'b1;
    end
  end

  // Select the winning requester's operand slices. The mux uses constant
  // slice bases.
  always_comb begin
    w_selA = '0;
    w_selB = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grantId == IDW'(i)) begin
        w_selA = req_a[i*WIDTH +: WIDTH];
        w_selB = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Main sequencer: IDLE -> ISSUE -> WAIT -> RESP. The round-robin pointer
  // moves only after the response has been accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lastGrant <= IDW'(NREQ - 1);
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_product   <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a     <= w_selA;
            r_b     <= w_selB;
            r_id    <= w_grantId;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (mul_done) begin
            r_product <= mul_product;
            r_err     <= 1'b0;
            r_state   <= S_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_product <= '0;
            r_err     <= 1'b1;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_lastGrant <= r_id;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE) ? w_grant : '0;
  assign mul_start   = (r_state == S_ISSUE);
  assign mul_a       = r_a;
  assign mul_b       = r_b;
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_id      = r_id;
  assign rsp_product = r_product;
  assign rsp_err     = r_err;
  assign busy        = (r_state != S_IDLE);

endmodule
